// File: rtl/kpn_pkg.sv
// Shared KPN constants and token type: default channel geometry and stall counter width.
// Every KPN block imports this so edge widths and counter widths agree across the graph.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH  = 16;
  localparam int KPN_ADDR_WIDTH  = 5;
  localparam int KPN_STALL_WIDTH = 16;

  typedef logic [KPN_DATA_WIDTH-1:0] kpn_token_t;

endpackage

// File: rtl/kpn_fifo_ram.sv
// Simple dual-port token store: synchronous write, asynchronous read.
// Zero-cycle read latency; no flow control of its own, the owner gates the write enable.
module kpn_fifo_ram
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int ADDR_WIDTH = KPN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kpn_channel_fifo.sv
// KPN edge FIFO, first-word-fall-through: token readable one cycle after its push; all flags from registered count.
// Blocks writes when full and reads when empty; KPN_FIFO_STATS_EN adds peak_count/stall_cycles outputs.
module kpn_channel_fifo
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH   = KPN_DATA_WIDTH,
  parameter int ADDR_WIDTH   = KPN_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef KPN_FIFO_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]      peak_count,
  output logic [KPN_STALL_WIDTH-1:0] stall_cycles
`endif
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  ram_we;

  // Full/empty come from the occupancy count; equal pointers alone are ambiguous.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign wr_ready     = !full;
  assign rd_valid     = !empty;
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Gating by registered flags is what blocks the pop on empty and the push on full.
  assign push   = wr_valid && wr_ready;
  assign pop    = rd_valid && rd_ready;
  assign ram_we = push && !rst && !flush;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        w_ptr <= w_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
      count <= count_next;
    end
  end

  kpn_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_ptr),
    .wdata (wr_data),
    .raddr (r_ptr),
    .rdata (rd_data)
  );

`ifdef KPN_FIFO_STATS_EN
  localparam logic [KPN_STALL_WIDTH-1:0] STALL_MAX = '1;

  // Peak tracks the post-edge occupancy so it never lags count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      peak_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (count_next > peak_count) begin
        peak_count <= count_next;
      end
      if (wr_valid && !wr_ready && (stall_cycles != STALL_MAX)) begin
        stall_cycles <= stall_cycles + KPN_STALL_WIDTH'(1);
      end
    end
  end
`endif

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Scoreboard bench for kpn_channel_fifo at DEPTH=4: data checked on every pop, occupancy every cycle.
module tb_kpn_channel_fifo;
  import kpn_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
`ifdef KPN_FIFO_STATS_EN
  logic [AW:0]   peak_count;
  logic [15:0]   stall_cycles;
`endif

  int tests = 0;
  int fails = 0;
  kpn_token_t sb[$];
  int m_peak;
  int m_stall;

  kpn_channel_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_LEVEL  (3),
    .AEMPTY_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef KPN_FIFO_STATS_EN
    ,
    .peak_count   (peak_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // One clock of stimulus; model predicts push/pop from its own occupancy.
  task automatic cycle(input logic wv, input kpn_token_t wd, input logic rr, input logic fl);
    logic exp_push;
    logic exp_pop;
    logic [CW-1:0] exp_cnt;
    exp_push = wv && (sb.size() < DEPTH);
    exp_pop  = rr && (sb.size() > 0);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    if (exp_pop && !fl) begin
      tests++;
      if (rd_data !== sb[0]) begin
        fails++;
        $display("FAIL pop_data: got %h expected %h", rd_data, sb[0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (fl) begin
      sb.delete();
      m_peak  = 0;
      m_stall = 0;
    end else begin
      if (wv && !exp_push) m_stall++;
      if (exp_pop) void'(sb.pop_front());
      if (exp_push) sb.push_back(wd);
      if (sb.size() > m_peak) m_peak = sb.size();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    exp_cnt  = CW'(sb.size());
    tests++;
    if (count !== exp_cnt) begin
      fails++;
      $display("FAIL count_track: got %0d expected %0d", count, exp_cnt);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_peak  = 0;
    m_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got cnt=%0d rv=%b wr=%b ae=%b af=%b expected 0 0 1 1 0",
               count, rd_valid, wr_ready, almost_empty, almost_full);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    cycle(1'b1, 16'h0011, 1'b0, 1'b0);
    tests++;
    if (almost_empty !== 1'b1 || rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL fill_cnt1: got ae=%b rv=%b expected 1 1", almost_empty, rd_valid);
    end
    cycle(1'b1, 16'h0022, 1'b0, 1'b0);
    tests++;
    if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL fill_cnt2: got ae=%b af=%b expected 0 0", almost_empty, almost_full);
    end
    cycle(1'b1, 16'h0033, 1'b0, 1'b0);
    tests++;
    if (almost_full !== 1'b1 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_cnt3: got af=%b wr=%b expected 1 1", almost_full, wr_ready);
    end
    cycle(1'b1, 16'h0044, 1'b0, 1'b0);
    tests++;
    if (wr_ready !== 1'b0 || count !== 3'd4 || almost_full !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: got wr=%b cnt=%0d af=%b expected 0 4 1", wr_ready, count, almost_full);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_empty: got rv=%b wr=%b expected 0 1", rd_valid, wr_ready);
    end
  endtask

  task automatic test_empty_simul();
    do_reset();
    cycle(1'b1, 16'h00AA, 1'b1, 1'b0);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h00AA || count !== 3'd1) begin
      fails++;
      $display("FAIL empty_simul: got rv=%b data=%h cnt=%0d expected 1 00aa 1", rd_valid, rd_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, kpn_token_t'(16'h0101 * i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0055, 1'b1, 1'b0);
    tests++;
    if (count !== 3'd3 || wr_ready !== 1'b1 || rd_data !== 16'h0202) begin
      fails++;
      $display("FAIL full_simul: got cnt=%0d wr=%b head=%h expected 3 1 0202", count, wr_ready, rd_data);
    end
    cycle(1'b1, 16'h0055, 1'b0, 1'b0);
    tests++;
    if (count !== 3'd4) begin
      fails++;
      $display("FAIL full_retry: got cnt=%0d expected 4", count);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (rd_data !== 16'h0055) begin
      fails++;
      $display("FAIL full_last: got %h expected 0055", rd_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    cycle(1'b1, 16'h0101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, kpn_token_t'(16'h0200 + i), 1'b1, 1'b0);
      tests++;
      if (count !== 3'd2) begin
        fails++;
        $display("FAIL wrap_count: got %0d expected 2 at step %0d", count, i);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, kpn_token_t'(16'h0060 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0066, 1'b0, 1'b1);
    tests++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || almost_empty !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: got cnt=%0d rv=%b wr=%b ae=%b expected 0 0 1 1",
               count, rd_valid, wr_ready, almost_empty);
    end
    cycle(1'b1, 16'h0077, 1'b0, 1'b0);
    tests++;
    if (rd_data !== 16'h0077 || rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_first: got data=%h rv=%b expected 0077 1", rd_data, rd_valid);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stats_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, kpn_token_t'(16'h00A0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h00EE, 1'b0, 1'b0);
`ifdef KPN_FIFO_STATS_EN
    tests++;
    if (stall_cycles !== 16'd5 || peak_count !== 3'd4) begin
      fails++;
      $display("FAIL stats_pre: got stall=%0d peak=%0d expected 5 4 (model %0d %0d)",
               stall_cycles, peak_count, m_stall, m_peak);
    end
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    // Reset lands while both sides are still handshaking.
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0099;
    rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    sb.delete();
    m_peak  = 0;
    m_stall = 0;
    tests++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: got cnt=%0d rv=%b wr=%b ae=%b af=%b expected 0 0 1 1 0",
               count, rd_valid, wr_ready, almost_empty, almost_full);
    end
`ifdef KPN_FIFO_STATS_EN
    tests++;
    if (stall_cycles !== 16'd0 || peak_count !== 3'd0) begin
      fails++;
      $display("FAIL stats_cleared: got stall=%0d peak=%0d expected 0 0", stall_cycles, peak_count);
    end
`endif
    cycle(1'b1, 16'h005A, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    m_peak   = 0;
    m_stall  = 0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_empty_simul();
    test_full_simul();
    test_wrap();
    test_flush();
    test_stats_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
